meas_tx_arbiter: RTL and testbench
==================================

# meas_tx_arbiter

Round-robin scheduler that shares the single AXI-Stream frame transmitter of the frequency meter between `N_CH` measurement channels. Each channel posts a result as a one-cycle strobe with data. The block buffers one result per channel, grants the transmitter to one channel at a time, and drives the transmitter's `send_packet`/`data_in` pair. It tracks overruns and transmitter timeouts.

## Interface
- `N_CH`, 4, number of measurement channels (2..16)
- `DATA_W`, 16, result width; equals transmitter `data_in` width
- `BUSY_TIMEOUT`, 1024, max cycles to wait for `tx_busy` to rise after a send pulse (≥2)

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `ch_valid`  in  N_CH  per-channel result strobe, one cycle
- `ch_data`  in  N_CH*DATA_W  per-channel result; channel i occupies bits [i*DATA_W +: DATA_W]
- `tx_send`  out  1  one-cycle request to transmitter (drives `send_packet`)
- `tx_data`  out  DATA_W  result being sent (drives `data_in`), held stable from `tx_send` until frame done
- `tx_id`  out  $clog2(N_CH)  channel index of current frame
- `tx_busy`  in  1  transmitter frame in progress
- `ch_pending`  out  N_CH  per-channel buffered-result flag
- `ovr`  out  N_CH  sticky overrun flags
- `err_timeout`  out  1  sticky transmitter-timeout flag
- `flags_clr`  in  1  clears `ovr` and `err_timeout`

## Operation
- Per-channel slot: `pend[i]` plus `buf[i]`.
  - `ch_valid[i]` loads `buf[i]` and sets `pend[i]`.
  - If `pend[i]` is already set and the slot is not being granted in that cycle, newest data overwrites the old and `ovr[i]` sets.
- FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if any `pend` is set, pick the first set index searching from `last+1` modulo N_CH. Latch `buf[g]` into `tx_data` and `g` into `tx_id`, clear `pend[g]`, go to ISSUE.
  - ISSUE: `tx_send`=1 for exactly this cycle. Set `last`=`tx_id`. Go to WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy`=1, go to WAIT_DONE. Otherwise increment the timeout counter. At `BUSY_TIMEOUT` cycles, set `err_timeout`, drop the frame and go to IDLE.
  - WAIT_DONE: when `tx_busy`=0, go to IDLE.
- Grant/strobe in the same cycle on the same channel:
  - Grant takes the old `buf[g]`. New data loads `buf[g]` and `pend[g]` stays set. No overrun.
- `flags_clr` has priority below set: if a set and a clear hit the same flag in the same cycle, the flag ends up set.
- `tx_data`/`tx_id` change only on the IDLE→ISSUE transition.

## Timing
- Reset (`rst_n`=0 at a clock edge), next cycle:
  - state=IDLE, `last`=N_CH-1 (so channel 0 wins first)
  - `tx_send`=0, `tx_data`=0, `tx_id`=0
  - `pend`=0, `buf`=0, `ovr`=0, `err_timeout`=0, timeout counter=0
- Reset mid-frame abandons the frame. Results are lost; no `tx_send` is issued after reset is released until a new strobe arrives.
- Latency with transmitter idle: `ch_valid` at cycle t → `pend` visible at t+1 → ISSUE at t+2, so `tx_send`=1 in cycle t+2.
- Minimum spacing of successive `tx_send` pulses: 4 cycles (ISSUE, WAIT_BUSY with `tx_busy` already high, WAIT_DONE with `tx_busy` low, IDLE).
- Timeout counter resets on entry to WAIT_BUSY. With `tx_busy` stuck low, `err_timeout` sets `BUSY_TIMEOUT` cycles after ISSUE.
- Arbitration is fair: each pending channel is granted within N_CH frames.
- All outputs are registered; none depends combinationally on inputs.

## Test plan
- Single result: `ch_valid[2]` with 16'h1234; model asserts `tx_busy` for 5 cycles after `tx_send`. Required: `tx_send` 2 cycles after the strobe, `tx_data`=16'h1234, `tx_id`=2, `pend[2]` clears, no further `tx_send`.
- Simultaneous strobes on all 4 channels (data 10, 20, 30, 40) after reset: frames go out in id order 0, 1, 2, 3 with matching data. Repeat with `last`=1: order 2, 3, 0, 1.
- Overrun: two strobes on ch1 (16'hAAAA then 16'hBBBB) while the transmitter is busy with ch0. Required: ch1 sends 16'hBBBB and `ovr[1]`=1. `flags_clr` then clears it.
- Same-cycle grant and strobe on ch0: ch0 frame carries the old value. `pend[0]` stays 1 and the next frame carries the new value; `ovr[0]`=0.
- Timeout: `tx_busy` held 0, `BUSY_TIMEOUT`=8. Required: `err_timeout`=1 exactly 8 cycles after `tx_send`, FSM back in IDLE, the next pending channel is served.
- Reset in WAIT_DONE with 2 channels pending: all outputs return to reset values, and no `tx_send` occurs until a new strobe arrives.

Source files
------------

// File: rtl/meas_tx_arbiter.sv
// rtl/meas_tx_arbiter.sv - round-robin scheduler sharing one frame transmitter between measurement channels
module meas_tx_arbiter #(
    parameter int N_CH         = 4,
    parameter int DATA_W       = 16,
    parameter int BUSY_TIMEOUT = 1024,
    localparam int ID_W        = $clog2(N_CH),
    localparam int CNT_W       = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    output logic                     tx_send,
    output logic [DATA_W-1:0]        tx_data,
    output logic [ID_W-1:0]          tx_id,
    input  logic                     tx_busy,
    output logic [N_CH-1:0]          ch_pending,
    output logic [N_CH-1:0]          ovr,
    output logic                     err_timeout,
    input  logic                     flags_clr
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              state;
    logic [ID_W-1:0]     last;
    logic [CNT_W-1:0]    cnt;
    logic [N_CH-1:0]     pend;
    logic [DATA_W-1:0]   slot_data [N_CH];

    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     idx;
    logic                grant_fire;

    // Scan downward so the candidate closest after 'last' is written last and wins.
    always_comb begin
        grant_id = '0;
        idx      = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = ID_W'((int'(last) + k) % N_CH);
            if (pend[idx]) begin
                grant_id = idx;
            end
        end
    end

    assign grant_fire = (state == IDLE) && (|pend);
    assign ch_pending = pend;

    // A strobe arriving on the slot being granted refills it; the grant keeps the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
            ovr  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_valid[i]) begin
                    slot_data[i] <= ch_data[i*DATA_W +: DATA_W];
                    pend[i]      <= 1'b1;
                end else if (grant_fire && (grant_id == ID_W'(i))) begin
                    pend[i] <= 1'b0;
                end
                ovr[i] <= (ovr[i] & ~flags_clr)
                        | (ch_valid[i] & pend[i] & ~(grant_fire && (grant_id == ID_W'(i))));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= ID_W'(N_CH - 1);
            cnt         <= '0;
            tx_send     <= 1'b0;
            tx_data     <= '0;
            tx_id       <= '0;
            err_timeout <= 1'b0;
        end else begin
            tx_send     <= 1'b0;
            err_timeout <= err_timeout & ~flags_clr;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        tx_data <= slot_data[grant_id];
                        tx_id   <= grant_id;
                        tx_send <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    last  <= tx_id;
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Final count value is chosen so the flag is visible BUSY_TIMEOUT cycles after tx_send.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 2)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meas_tx_arbiter.sv
// tb/tb_meas_tx_arbiter.sv - scoreboard bench for meas_tx_arbiter with a frame-level reference model
module tb_meas_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int T  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    ch_valid = '0;
    logic [N*DW-1:0] ch_data = '0;
    logic            tx_send;
    logic [DW-1:0]   tx_data;
    logic [IW-1:0]   tx_id;
    logic            tx_busy = 1'b0;
    logic [N-1:0]    ch_pending;
    logic [N-1:0]    ovr;
    logic            err_timeout;
    logic            flags_clr = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    meas_tx_arbiter #(.N_CH(N), .DATA_W(DW), .BUSY_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_data(ch_data),
        .tx_send(tx_send), .tx_data(tx_data), .tx_id(tx_id), .tx_busy(tx_busy),
        .ch_pending(ch_pending), .ovr(ovr), .err_timeout(err_timeout), .flags_clr(flags_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    exp_t exq[$];
    int   blen_q[$];

    // Reference model: per-channel mailbox plus the cycle at which the scheduler is next free.
    logic [N-1:0]  m_pend, m_ovr;
    logic          m_err;
    logic [DW-1:0] m_buf [N];
    int            m_last, avail, busy_from, busy_to, err_at;
    bit            post_rst;

    logic [N-1:0]    s_v = '0;
    logic [N*DW-1:0] s_d = '0;
    logic            s_clr = 1'b0;
    logic            s_rst = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_ovr = '0;
        m_err = 1'b0;
        for (int i = 0; i < N; i++) m_buf[i] = '0;
        m_last = N - 1;
        avail = 0;
        busy_from = 0;
        busy_to = -1;
        err_at = -1;
    endtask

    task automatic step();
        int g, s, L, idx;
        logic [IW-1:0] gi;
        logic [N-1:0] setv;
        @(negedge clk);
        #1;
        check("flags", {ch_pending, ovr, err_timeout}, {m_pend, m_ovr, m_err});
        if (post_rst) check("rst_outputs", {tx_send, tx_data, tx_id}, '0);
        post_rst = 1'b0;
        if (s_rst) begin
            rst_n = 1'b0;
            ch_valid = '0;
            flags_clr = 1'b0;
            tx_busy = 1'b0;
            model_reset();
            exq.delete();
            post_rst = 1'b1;
            return;
        end
        rst_n = 1'b1;
        if (cyc >= avail && m_pend != '0) begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && m_pend[idx[IW-1:0]]) g = idx;
            end
            gi = g[IW-1:0];
            s = cyc + 1;
            exq.push_back('{g, m_buf[gi], s});
            m_pend[gi] = 1'b0;
            m_last = g;
            if (blen_q.size() > 0) L = blen_q.pop_front();
            else L = int'($urandom_range(0, 6));
            if (L == 0) begin
                busy_from = 0; busy_to = -1; err_at = s + T; avail = s + T;
            end else begin
                busy_from = s + 1; busy_to = s + L; err_at = -1; avail = s + L + 2;
            end
        end
        tx_busy = (cyc >= busy_from) && (cyc <= busy_to);
        setv = s_v & m_pend;
        m_ovr = (m_ovr & ~{N{s_clr}}) | setv;
        m_err = (m_err & ~s_clr) | (cyc + 1 == err_at);
        for (int i = 0; i < N; i++) begin
            if (s_v[i]) begin
                m_buf[i] = s_d[i*DW +: DW];
                m_pend[i] = 1'b1;
            end
        end
        ch_valid = s_v;
        ch_data = s_d;
        flags_clr = s_clr;
    endtask

    task automatic idle(input int k);
        s_v = '0;
        s_clr = 1'b0;
        repeat (k) step();
    endtask

    task automatic strobe(input int ch, input logic [DW-1:0] d);
        s_v = N'(1) << ch;
        s_d[ch*DW +: DW] = d;
        step();
        s_v = '0;
    endtask

    task automatic do_reset();
        s_v = '0;
        s_rst = 1'b1;
        step();
        step();
        s_rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a frame.
    logic [DW-1:0] last_sent = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exq.size() > 0 && exq[0].at < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_send id=%0d actual=none required_cycle=%0d cycle=%0d", exq[0].id, exq[0].at, cyc);
                void'(exq.pop_front());
            end
            if (tx_send) begin
                if (exq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_send actual id=%0d data=%0h required=none cycle=%0d", tx_id, tx_data, cyc);
                end else begin
                    e = exq.pop_front();
                    check("send_id", 64'(tx_id), 64'(e.id));
                    check("send_data", 64'(tx_data), 64'(e.data));
                    check("send_cycle", 64'(cyc), 64'(e.at));
                end
                last_sent = tx_data;
            end else if (tx_busy) begin
                check("data_hold", 64'(tx_data), 64'(last_sent));
            end
        end
    end

    initial begin
        model_reset();
        post_rst = 1'b1;
        do_reset();

        blen_q.push_back(5);
        strobe(2, 16'h1234);
        idle(15);

        blen_q = '{3, 3, 3, 3};
        s_v = 4'hF;
        s_d = {16'd40, 16'd30, 16'd20, 16'd10};
        step();
        idle(40);

        do_reset();
        blen_q.push_back(2);
        strobe(1, 16'h0011);
        idle(10);
        blen_q = '{2, 2, 2, 2};
        s_v = 4'hF;
        s_d = {16'd40, 16'd30, 16'd20, 16'd10};
        step();
        idle(40);

        blen_q = '{10, 2};
        strobe(0, 16'h0C0C);
        idle(3);
        strobe(1, 16'hAAAA);
        idle(1);
        strobe(1, 16'hBBBB);
        idle(25);
        check("ovr1_set", 64'(ovr[1]), 64'(1));
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        idle(2);
        check("ovr1_clr", 64'(ovr[1]), 64'(0));

        blen_q = '{2, 2};
        strobe(0, 16'h1111);
        strobe(0, 16'h2222);
        idle(20);
        check("ovr0_clear", 64'(ovr[0]), 64'(0));

        blen_q = '{0, 3};
        s_v = 4'b0110;
        s_d = {16'h0, 16'h3333, 16'h2222, 16'h0};
        step();
        idle(30);
        check("err_timeout_set", 64'(err_timeout), 64'(1));
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        idle(2);

        blen_q = '{10};
        s_v = 4'b0111;
        s_d = {16'h0, 16'h5555, 16'h6666, 16'h7777};
        step();
        idle(5);
        do_reset();
        idle(20);
        check("pend_after_rst", 64'(ch_pending), 64'(0));
        blen_q.push_back(3);
        strobe(3, 16'h4444);
        idle(15);

        repeat (2000) begin
            s_v = N'($urandom & $urandom & $urandom);
            s_d = {$urandom, $urandom};
            s_clr = ($urandom_range(0, 39) == 0);
            step();
        end
        idle(40);
        check("queue_empty", 64'(exq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
